// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: arbitration
// state encoding, requester index constants and default bus widths.
package dmem_port_arbiter_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    // Requester indices; also the encoding of last_grant and rd_owner.
    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    // ARB: open round-robin; LOCKn: port n holds the memory exclusively.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin picker. A masked port is never granted;
// on contention the port that did not win last time is chosen.
module dmem_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic mask0,
    input  logic mask1,
    output logic gnt0,
    output logic gnt1
);

    logic elig0;
    logic elig1;

    // Eligibility after masking, then alternate on contention.
    always_comb begin
        elig0 = valid0 & ~mask0;
        elig1 = valid1 & ~mask1;
        gnt0  = elig0 & (~elig1 | last_grant);
        gnt1  = elig1 & (~elig0 | ~last_grant);
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port synchronous dmem between the CPU port (0) and the
// host/debug port (1). Round-robin grant, bounded lock for read-modify-write,
// read data returned one cycle after acceptance, tagged to its requester.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_LOCK = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_wren,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_q,
    input  logic              req1_valid,
    input  logic              req1_wren,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_q,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    arb_state_t        state_reg,      state_next;
    logic              last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]  lock_cnt_reg,   lock_cnt_next;
    logic              rd_pend_reg,    rd_pend_next;
    logic              rd_owner_reg,   rd_owner_next;

    logic              pick0, pick1;
    logic              gnt0, gnt1;
    logic              mask0, mask1;
    logic              xfer, xfer_port, xfer_wren, xfer_lock;
    logic              lock_owner;
    logic [1:0]        rsp_valid_w;
    logic [DATA_W-1:0] rsp_q_w [2];

    assign mask0      = (state_reg == LOCK1);
    assign mask1      = (state_reg == LOCK0);
    assign lock_owner = (state_reg == LOCK1) ? PORT_HOST : PORT_CPU;

    dmem_rr_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_reg),
        .mask0      (mask0),
        .mask1      (mask1),
        .gnt0       (pick0),
        .gnt1       (pick1)
    );

    // Grants are suppressed while reset is held so no write can slip out.
    always_comb begin
        gnt0       = pick0 & ~reset;
        gnt1       = pick1 & ~reset;
        req0_ready = gnt0;
        req1_ready = gnt1;
        xfer       = gnt0 | gnt1;
        xfer_port  = gnt1 ? PORT_HOST : PORT_CPU;
        xfer_wren  = gnt1 ? req1_wren : (gnt0 & req0_wren);
        xfer_lock  = gnt1 ? req1_lock : (gnt0 & req0_lock);
    end

    // Memory bus mux: idle bus drives zeros.
    always_comb begin
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        if (gnt1) begin
            mem_wren    = req1_wren;
            mem_address = req1_addr;
            mem_data    = req1_data;
        end else if (gnt0) begin
            mem_wren    = req0_wren;
            mem_address = req0_addr;
            mem_data    = req0_data;
        end
    end

    // Next-state logic: lock entry/exit, lock timeout, read tagging.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        lock_cnt_next   = lock_cnt_reg;
        rd_pend_next    = 1'b0;
        rd_owner_next   = rd_owner_reg;

        if (xfer) begin
            last_grant_next = xfer_port;
            if (!xfer_wren) begin
                rd_pend_next  = 1'b1;
                rd_owner_next = xfer_port;
            end
        end

        case (state_reg)
            ARB: begin
                if (xfer && xfer_lock) begin
                    state_next    = xfer_port ? LOCK1 : LOCK0;
                    lock_cnt_next = CNT_ONE;
                end
            end
            LOCK0, LOCK1: begin
                if (xfer && !xfer_lock) begin
                    state_next    = ARB;
                    lock_cnt_next = '0;
                end else if (lock_cnt_reg == CNT_MAX) begin
                    // Timeout: hand priority to the peer on the next contention.
                    state_next      = ARB;
                    lock_cnt_next   = '0;
                    last_grant_next = lock_owner;
                end else begin
                    lock_cnt_next = lock_cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next    = ARB;
                lock_cnt_next = '0;
            end
        endcase
    end

    // State registers; reset drops any outstanding response and the lock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ARB;
            last_grant_reg <= PORT_HOST;
            lock_cnt_reg   <= '0;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= PORT_CPU;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            lock_cnt_reg   <= lock_cnt_next;
            rd_pend_reg    <= rd_pend_next;
            rd_owner_reg   <= rd_owner_next;
        end
    end

    // Response steering: memory q goes only to the port that issued the read.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_valid_w[gi] = rd_pend_reg & (rd_owner_reg == gi[0]);
            assign rsp_q_w[gi]     = rsp_valid_w[gi] ? mem_q : '0;
        end
    endgenerate

    assign rsp0_valid = rsp_valid_w[0];
    assign rsp1_valid = rsp_valid_w[1];
    assign rsp0_q     = rsp_q_w[0];
    assign rsp1_q     = rsp_q_w[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table, a reset
// corner sequence and randomized traffic against a behavioural model.
module tb_dmem_port_arbiter;

    localparam int MAX_LOCK = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_wren, req0_lock;
    logic [11:0] req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready, rsp0_valid;
    logic [31:0] rsp0_q;
    logic        req1_valid, req1_wren, req1_lock;
    logic [11:0] req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready, rsp1_valid;
    logic [31:0] rsp1_q;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    always #5 clock = ~clock;

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_wren(req0_wren), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_q(rsp0_q),
        .req1_valid(req1_valid), .req1_wren(req1_wren), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_q(rsp1_q),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    // Synchronous single-port memory attached to the arbiter.
    logic [31:0] dmem [4096];
    always @(posedge clock) begin
        if (mem_wren) dmem[mem_address] <= mem_data;
        mem_q <= dmem[mem_address];
    end

    // Behavioural model: who holds the lock (-1 = nobody), for how many
    // cycles, who won last, and the read result owed next cycle.
    int          m_owner, m_held, m_last;
    bit          m_pend;
    int          m_pend_port;
    logic [31:0] m_pend_data;
    logic [31:0] sm [4096];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        bit v0, w0, l0; logic [11:0] a0; logic [31:0] d0;
        bit v1, w1, l1; logic [11:0] a1; logic [31:0] d1;
        bit er0, er1, ev0, ev1;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cyc %0d %s: got %h expected %h", cyc, name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_last = 1; m_pend = 0; m_pend_port = 0; m_pend_data = '0;
    endtask

    function automatic int model_winner();
        bit c0, c1;
        c0 = req0_valid && (m_owner != 1);
        c1 = req1_valid && (m_owner != 0);
        if (c0 && c1) return (m_last == 0) ? 1 : 0;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    // Called at posedge+1 with inputs set; checks mid-cycle, advances one edge.
    task automatic run_cycle(input bit has_exp, input vec_t v);
        int          w;
        bit          wr, lk;
        logic [11:0] ad;
        logic [31:0] dt;
        #2;
        w  = model_winner();
        wr = (w == 1) ? req1_wren : req0_wren;
        lk = (w == 1) ? req1_lock : req0_lock;
        ad = (w == 1) ? req1_addr : req0_addr;
        dt = (w == 1) ? req1_data : req0_data;
        if (has_exp) begin
            chk("tbl_ready0", 32'(req0_ready), 32'(v.er0));
            chk("tbl_ready1", 32'(req1_ready), 32'(v.er1));
            chk("tbl_rsp0_valid", 32'(rsp0_valid), 32'(v.ev0));
            chk("tbl_rsp1_valid", 32'(rsp1_valid), 32'(v.ev1));
        end
        chk("ready0", 32'(req0_ready), 32'(w == 0));
        chk("ready1", 32'(req1_ready), 32'(w == 1));
        chk("mem_wren", 32'(mem_wren), 32'((w >= 0) && wr));
        chk("mem_address", 32'(mem_address), (w >= 0) ? 32'(ad) : 32'd0);
        chk("mem_data", mem_data, (w >= 0) ? dt : 32'd0);
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_pend && m_pend_port == 0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_pend && m_pend_port == 1));
        chk("rsp0_q", rsp0_q, (m_pend && m_pend_port == 0) ? m_pend_data : 32'd0);
        chk("rsp1_q", rsp1_q, (m_pend && m_pend_port == 1) ? m_pend_data : 32'd0);
        if (w >= 0)
            $display("cyc %0d: port %0d %s addr %h data %h lock %0d", cyc, w,
                     wr ? "WR" : "RD", ad, wr ? dt : sm[ad], lk);
        @(posedge clock);
        // Model update for the edge just taken.
        m_pend = 0;
        if (w >= 0) begin
            m_last = w;
            if (wr) sm[ad] = dt;
            else begin m_pend = 1; m_pend_port = w; m_pend_data = sm[ad]; end
        end
        if (m_owner < 0) begin
            if (w >= 0 && lk) begin m_owner = w; m_held = 1; end
        end else if (w == m_owner && !lk) begin
            m_owner = -1;
        end else if (m_held >= MAX_LOCK) begin
            m_last  = m_owner;
            m_owner = -1;
        end else begin
            m_held++;
        end
        cyc++;
        #1;
    endtask

    task automatic apply(input vec_t v);
        req0_valid = v.v0; req0_wren = v.w0; req0_lock = v.l0; req0_addr = v.a0; req0_data = v.d0;
        req1_valid = v.v1; req1_wren = v.w1; req1_lock = v.l1; req1_addr = v.a1; req1_data = v.d1;
    endtask

    function automatic vec_t mk(bit v0, bit w0, bit l0, logic [11:0] a0, logic [31:0] d0,
                                bit v1, bit w1, bit l1, logic [11:0] a1, logic [31:0] d1,
                                bit er0, bit er1, bit ev0, bit ev1);
        vec_t r;
        r.v0 = v0; r.w0 = w0; r.l0 = l0; r.a0 = a0; r.d0 = d0;
        r.v1 = v1; r.w1 = w1; r.l1 = l1; r.a1 = a1; r.d1 = d1;
        r.er0 = er0; r.er1 = er1; r.ev0 = ev0; r.ev1 = ev1;
        return r;
    endfunction

    initial begin
        vec_t idle_v, v;
        for (int i = 0; i < 4096; i++) begin
            dmem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
            sm[i]   = 32'h5A00_0000 ^ (i * 32'h0001_0203);
        end
        idle_v = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0);

        // Single port write then read, response one cycle later.
        tbl.push_back(mk(1,1,0,12'h010,32'hDEADBEEF, 0,0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,12'h010,0,            0,0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
        // Both ports read every cycle: grants alternate.
        tbl.push_back(mk(1,0,0,12'h001,0, 1,0,0,12'h002,0, 0,1,0,0));
        tbl.push_back(mk(1,0,0,12'h001,0, 1,0,0,12'h002,0, 1,0,0,1));
        tbl.push_back(mk(1,0,0,12'h001,0, 1,0,0,12'h002,0, 0,1,1,0));
        tbl.push_back(mk(1,0,0,12'h001,0, 1,0,0,12'h002,0, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
        // Host read-modify-write under lock, CPU blocked until after unlock.
        tbl.push_back(mk(1,0,0,12'h001,0, 1,0,1,12'h020,0,            0,1,0,0));
        tbl.push_back(mk(1,0,0,12'h001,0, 1,1,0,12'h020,32'h12345678, 0,1,0,1));
        tbl.push_back(mk(1,0,0,12'h001,0, 0,0,0,0,0,                  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
        // Host locks then idles: CPU blocked for MAX_LOCK cycles.
        tbl.push_back(mk(1,0,0,12'h001,0, 1,0,1,12'h020,0, 0,1,0,0));
        tbl.push_back(mk(1,0,0,12'h001,0, 0,0,0,0,0,       0,0,0,1));
        for (int i = 0; i < MAX_LOCK - 1; i++)
            tbl.push_back(mk(1,0,0,12'h001,0, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,12'h001,0, 1,0,0,12'h002,0, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
        // Back-to-back CPU reads.
        tbl.push_back(mk(1,0,0,12'h003,0, 0,0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,12'h004,0, 0,0,0,0,0, 1,0,1,0));
        tbl.push_back(mk(1,0,0,12'h005,0, 0,0,0,0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
        // Lock request from the losing port is ignored.
        tbl.push_back(mk(1,0,1,12'h006,0, 1,0,0,12'h007,0, 0,1,0,0));
        tbl.push_back(mk(1,0,0,12'h006,0, 0,0,0,0,0,       1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,12'h007,0,       0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,             0,0,0,1));

        // Reset state, with requests present.
        reset = 1'b1;
        apply(mk(1,1,0,12'h0FF,32'hFFFF_FFFF, 1,1,0,12'h0FE,32'hFFFF_FFFF, 0,0,0,0));
        repeat (2) @(posedge clock);
        #3;
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        chk("rst_mem_wren", 32'(mem_wren), 0);
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        apply(idle_v);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            run_cycle(1'b1, tbl[i]);
        end

        // Reset in the cycle after a CPU read is accepted.
        v = mk(1,0,0,12'h010,0, 0,0,0,0,0, 1,0,0,0);
        apply(v);
        run_cycle(1'b1, v);
        apply(mk(1,1,0,12'h011,32'hCAFE_F00D, 1,1,0,12'h012,32'hBADD_CAFE, 0,0,0,0));
        reset = 1'b1;
        #1;
        chk("midrst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("midrst_rsp0_q", rsp0_q, 0);
        chk("midrst_ready", 32'({req0_ready, req1_ready}), 0);
        chk("midrst_mem_wren", 32'(mem_wren), 0);
        @(posedge clock);
        #1;
        chk("midrst_mem_wren2", 32'(mem_wren), 0);
        reset = 1'b0;
        model_reset();
        v = mk(1,0,0,12'h011,0, 1,0,0,12'h012,0, 1,0,0,0);
        apply(v);
        run_cycle(1'b1, v);
        apply(idle_v);
        run_cycle(1'b0, idle_v);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v.v0 = ($urandom_range(0, 9) < 7); v.w0 = ($urandom_range(0, 9) < 4);
            v.l0 = ($urandom_range(0, 9) < 2); v.a0 = 12'($urandom_range(0, 15)); v.d0 = $urandom;
            v.v1 = ($urandom_range(0, 9) < 7); v.w1 = ($urandom_range(0, 9) < 4);
            v.l1 = ($urandom_range(0, 9) < 2); v.a1 = 12'($urandom_range(0, 15)); v.d1 = $urandom;
            apply(v);
            run_cycle(1'b0, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
